// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with B-starvation override and
// read-after-write hazard flags against the staged (registered) write.
module reg_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ready,
   input  logic [4:0]  rd_addr1,
   input  logic [4:0]  rd_addr2,
   output logic [4:0]  addr3,
   output logic [31:0] din,
   output logic        regWrite,
   output logic        hazard1,
   output logic        hazard2
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   localparam logic [0:0] PRIO_A = 1'b0;
   localparam logic [0:0] PRIO_B = 1'b1;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    addr3_q, addr3_d;
   logic [DW-1:0]    din_q, din_d;
   logic             regwrite_q, regwrite_d;
   logic             a_rdy, b_rdy;

   // Grant selection; nothing is accepted while reset is held.
   always_comb begin
      a_rdy = 1'b0;
      b_rdy = 1'b0;
      if (rst) begin
         if (state_q == PRIO_A) begin
            a_rdy = a_valid;
            b_rdy = b_valid && !a_valid;
         end else begin
            b_rdy = b_valid;
            a_rdy = a_valid && !b_valid;
         end
      end
   end

   // Starvation counter, next state and staged write.
   always_comb begin
      cnt_d      = '0;
      state_d    = state_q;
      addr3_d    = addr3_q;
      din_d      = din_q;
      regwrite_d = 1'b0;

      if (b_valid && !b_rdy) begin
         cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
      end

      case (state_q)
         PRIO_A:  if (cnt_d == LIMIT) state_d = PRIO_B;
         PRIO_B:  if (b_rdy || !b_valid) state_d = PRIO_A;
         default: state_d = PRIO_A;
      endcase

      if (a_rdy) begin
         addr3_d    = a_addr;
         din_d      = a_data;
         regwrite_d = (a_addr != '0);
      end else if (b_rdy) begin
         addr3_d    = b_addr;
         din_d      = b_data;
         regwrite_d = (b_addr != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= PRIO_A;
         cnt_q      <= '0;
         addr3_q    <= '0;
         din_q      <= '0;
         regwrite_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr3_q    <= addr3_d;
         din_q      <= din_d;
         regwrite_q <= regwrite_d;
      end
   end

   assign a_ready  = a_rdy;
   assign b_ready  = b_rdy;
   assign addr3    = addr3_q;
   assign din      = din_q;
   assign regWrite = regwrite_q;
   assign hazard1  = regwrite_q && (addr3_q == rd_addr1) && (rd_addr1 != '0);
   assign hazard2  = regwrite_q && (addr3_q == rd_addr2) && (rd_addr2 != '0);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, writes, zero register,
// starvation override, simultaneous requests, hazards and mid-run reset.
module tb_reg_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic [4:0]  rd_addr1, rd_addr2;
   logic [4:0]  addr3;
   logic [31:0] din;
   logic        regWrite, hazard1, hazard2;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   reg_write_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .addr3(addr3), .din(din), .regWrite(regWrite),
      .hazard1(hazard1), .hazard2(hazard2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hAAAA_0005;
      b_valid = 1'b0; b_addr = '0; b_data = '0; rd_addr1 = '0; rd_addr2 = '0;
      tick(); tick();
      total++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready got=%b exp=0", a_ready); else passed++;
      total++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready got=%b exp=0", b_ready); else passed++;
      total++; if (regWrite !== 1'b0) $display("FAIL rst_regwrite got=%b exp=0", regWrite); else passed++;
      total++; if (addr3 !== 5'd0) $display("FAIL rst_addr3 got=%0d exp=0", addr3); else passed++;
      total++; if (din !== 32'd0) $display("FAIL rst_din got=%h exp=0", din); else passed++;
      rst = 1'b1; #1;
      total++; if (a_ready !== 1'b1) $display("FAIL rst_rel_a_ready got=%b exp=1", a_ready); else passed++;
      tick(); a_valid = 1'b0;
      total++; if (regWrite !== 1'b1 || addr3 !== 5'd5 || din !== 32'hAAAA_0005)
         $display("FAIL rst_rel_write got=%b/%0d/%h exp=1/5/aaaa0005", regWrite, addr3, din); else passed++;
      tick();
   endtask

   task automatic test_single_write();
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1111_1111; #1;
      total++; if (a_ready !== 1'b1) $display("FAIL single_a_ready got=%b exp=1", a_ready); else passed++;
      tick(); a_valid = 1'b0;
      total++; if (regWrite !== 1'b1 || addr3 !== 5'd1 || din !== 32'h1111_1111)
         $display("FAIL single_write got=%b/%0d/%h exp=1/1/11111111", regWrite, addr3, din); else passed++;
      tick();
      total++; if (regWrite !== 1'b0) $display("FAIL single_idle_regwrite got=%b exp=0", regWrite); else passed++;
      total++; if (addr3 !== 5'd1 || din !== 32'h1111_1111)
         $display("FAIL single_hold got=%0d/%h exp=1/11111111", addr3, din); else passed++;
   endtask

   task automatic test_zero_reg();
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234_5678; #1;
      total++; if (b_ready !== 1'b1 || a_ready !== 1'b0)
         $display("FAIL zero_ready got=a%b/b%b exp=a0/b1", a_ready, b_ready); else passed++;
      tick(); b_valid = 1'b0;
      total++; if (regWrite !== 1'b0) $display("FAIL zero_regwrite got=%b exp=0", regWrite); else passed++;
      total++; if (addr3 !== 5'd0 || din !== 32'h1234_5678)
         $display("FAIL zero_load got=%0d/%h exp=0/12345678", addr3, din); else passed++;
      tick();
   endtask

   task automatic test_simultaneous();
      a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h2222_2222;
      b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h3333_3333; #1;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
         $display("FAIL simul_c0_ready got=a%b/b%b exp=a1/b0", a_ready, b_ready); else passed++;
      tick(); a_valid = 1'b0; #1;
      total++; if (regWrite !== 1'b1 || addr3 !== 5'd2 || din !== 32'h2222_2222)
         $display("FAIL simul_a_write got=%b/%0d/%h exp=1/2/22222222", regWrite, addr3, din); else passed++;
      total++; if (b_ready !== 1'b1) $display("FAIL simul_c1_b_ready got=%b exp=1", b_ready); else passed++;
      tick(); b_valid = 1'b0;
      total++; if (regWrite !== 1'b1 || addr3 !== 5'd3 || din !== 32'h3333_3333)
         $display("FAIL simul_b_write got=%b/%0d/%h exp=1/3/33333333", regWrite, addr3, din); else passed++;
      tick();
      total++; if (regWrite !== 1'b0) $display("FAIL simul_no_dup got=%b exp=0", regWrite); else passed++;
   endtask

   task automatic test_starvation();
      logic exp_b;
      a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h6666_6666;
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h7777_7777;
      for (int i = 0; i < 8; i++) begin
         #1;
         exp_b = ((i % 4) == 3);
         total++; if (a_ready !== !exp_b || b_ready !== exp_b)
            $display("FAIL starve_grant_c%0d got=a%b/b%b exp=a%b/b%b", i, a_ready, b_ready, !exp_b, exp_b);
         else passed++;
         tick();
         total++; if (regWrite !== 1'b1 || addr3 !== (exp_b ? 5'd7 : 5'd6))
            $display("FAIL starve_write_c%0d got=%b/%0d exp=1/%0d", i, regWrite, addr3, exp_b ? 7 : 6);
         else passed++;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
   endtask

   task automatic test_hazard();
      a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h0000_0022;
      rd_addr1 = 5'd2; rd_addr2 = 5'd0;
      tick(); a_valid = 1'b0; #1;
      total++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0)
         $display("FAIL hazard_active got=%b/%b exp=1/0", hazard1, hazard2); else passed++;
      rd_addr2 = 5'd2; rd_addr1 = 5'd4; #1;
      total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b1)
         $display("FAIL hazard_port2 got=%b/%b exp=0/1", hazard1, hazard2); else passed++;
      rd_addr1 = 5'd2; rd_addr2 = 5'd0;
      tick();
      total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
         $display("FAIL hazard_clear got=%b/%b exp=0/0", hazard1, hazard2); else passed++;
      rd_addr1 = '0;
   endtask

   task automatic test_mid_reset();
      a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9999_9999;
      tick();
      rst = 1'b0; #1;
      total++; if (a_ready !== 1'b0) $display("FAIL midrst_a_ready got=%b exp=0", a_ready); else passed++;
      tick();
      total++; if (regWrite !== 1'b0 || addr3 !== 5'd0)
         $display("FAIL midrst_drop got=%b/%0d exp=0/0", regWrite, addr3); else passed++;
      rst = 1'b1; #1;
      total++; if (a_ready !== 1'b1) $display("FAIL midrst_rel_ready got=%b exp=1", a_ready); else passed++;
      tick(); a_valid = 1'b0;
      total++; if (regWrite !== 1'b1 || addr3 !== 5'd9)
         $display("FAIL midrst_rel_write got=%b/%0d exp=1/9", regWrite, addr3); else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_zero_reg();
      test_simultaneous();
      test_starvation();
      test_hazard();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive cycles requester B may wait while valid before it is force-granted (legal range 1-15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 a_valid, a_addr[4:0], a_data[31:0]  input  1/5/32  requester A (pipeline writeback) write request.
REQ-005 a_ready  output  1  A's request is accepted this cycle.
REQ-006 b_valid, b_addr[4:0], b_data[31:0]  input  1/5/32  requester B (multi-cycle unit) write request.
REQ-007 b_ready  output  1  B's request is accepted this cycle.
REQ-008 rd_addr1, rd_addr2  input  5 each  register-file read addresses, used for hazard checks.
REQ-009 addr3 [4:0], din [31:0], regWrite [0]  output  5/32/1  register-file write port, driven from registers.
REQ-010 hazard1, hazard2  output  1 each  a read of rd_addr1 or rd_addr2 targets a write staged but not yet committed.

Function
REQ-011 The arbiter SHALL have two states: PRIO_A (the normal state) and PRIO_B (the forced state).
REQ-012 Handshake: a request is accepted when valid && ready; a_ready and b_ready are combinational and never both 1 in the same cycle.
REQ-013 In PRIO_A: a_ready = a_valid; b_ready = b_valid && !a_valid.
REQ-014 In PRIO_B: b_ready = b_valid; a_ready = a_valid && !b_valid.
REQ-015 The starvation counter is 4 bits wide. When b_valid && !b_ready, it increments and saturates at STARVE_LIMIT. In every other case it clears to 0.
REQ-016 Transition PRIO_A -> PRIO_B occurs on the edge where the counter's next value equals STARVE_LIMIT.
REQ-017 Transition PRIO_B -> PRIO_A occurs on the edge after B is accepted, or on the edge after a cycle in PRIO_B with b_valid=0.
REQ-018 Accepted request, latency 1: on the next edge addr3/din are loaded with the winner's addr/data, and regWrite is set to 1 only if addr != 0.
REQ-019 No acceptance in a cycle: regWrite is 0 on the next edge; addr3 and din hold their values.
REQ-020 A write to address 0 is accepted (ready=1) and consumes its slot, but never asserts regWrite.
REQ-021 Hazards: hazardN = regWrite && (addr3 == rd_addrN) && (rd_addrN != 0), purely combinational.
REQ-022 The requester SHALL keep its addr and data stable while valid && !ready. The arbiter does not buffer requests that are not accepted.
REQ-023 Inputs are don't-care while their valid is 0.

Reset
REQ-024 While rst=0, a_ready=0 and b_ready=0.
REQ-025 While rst=0, at the edge: state=PRIO_A, counter=0, regWrite=0, addr3=0, din=0.
REQ-026 Reset asserted mid-operation: any staged write is dropped (regWrite=0 on the following edge), no request is accepted in that cycle, and the first acceptance is possible in the first cycle with rst=1.

Verification
REQ-027 Reset: rst=0 for 2 cycles with a_valid=1 -> a_ready=0, regWrite=0, addr3=0, din=0; after rst=1 -> a_ready=1 and the next-edge write occurs.
REQ-028 Single write: a_valid=1, a_addr=1, a_data=32'h1111_1111 for one cycle -> next cycle regWrite=1, addr3=1, din=32'h1111_1111; the cycle after that regWrite=0.
REQ-029 Zero register: b_valid=1, b_addr=0, b_data=32'h1234_5678 with A idle -> b_ready=1; next cycle regWrite=0.
REQ-030 Starvation (STARVE_LIMIT=3): a_valid and b_valid held at 1 -> A granted in cycles 0-2, B granted in cycle 3, A granted again in cycle 4; the pattern repeats.
REQ-031 Simultaneous request, fresh state: a_addr=2/32'h2222_2222, b_addr=3/32'h3333_3333 -> A written first, B written on a later cycle, with no lost or duplicated writes.
REQ-032 Hazard: stage a write to addr 2 with rd_addr1=2 and rd_addr2=0 -> hazard1=1, hazard2=0 during the regWrite cycle; both are 0 the cycle after.
